// File: rtl/bit_error_window_pkg.sv
// Shared types and helpers for the bit-error window monitor: FSM state encoding
// and the byte popcount used on the received/reference difference.
package bit_error_window_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int BYTE_W = 8;
  localparam int POP_W  = 4;

  function automatic logic [POP_W-1:0] popcount8_f(input logic [BYTE_W-1:0] v);
    logic [POP_W-1:0] c;
    c = 4'd0;
    for (int i = 0; i < BYTE_W; i++) begin
      c = c + {3'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/bit_error_window_popcount8.sv
// Combinational ones-count of one byte; fed with rx_byte ^ ref_byte by the monitor.
module popcount8
  import bit_error_window_pkg::*;
(
  input  logic [7:0] in_i,
  output logic [3:0] cnt_o
);

  // Pure combinational count, no state.
  always_comb begin
    cnt_o = popcount8_f(in_i);
  end

endmodule

// File: rtl/bit_error_window.sv
// Bit-error window monitor: sums per-pair differing-bit counts over W_BYTES accepted
// pairs, saturating, and raises a held alarm when the window total reaches THRESH.
module bit_error_window
  import bit_error_window_pkg::*;
#(
  parameter int W_BYTES = 16,
  parameter int ACC_W   = 12,
  parameter int THRESH  = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             in_valid_i,
  input  logic [7:0]       rx_byte_i,
  input  logic [7:0]       ref_byte_i,
  output logic             in_ready_o,
  output logic [3:0]       byte_errs_o,
  output logic             byte_errs_valid_o,
  output logic [ACC_W-1:0] err_total_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             alarm_o
);

  localparam int                 CNT_W    = $clog2(W_BYTES) + 1;
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(W_BYTES - 1);
  localparam logic [ACC_W-1:0]   ACC_MAX  = {ACC_W{1'b1}};
  localparam logic [32:0]        THRESH_X = 33'(THRESH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] err_total_q, err_total_d;
  logic [3:0]       byte_errs_q, byte_errs_d;
  logic             byte_errs_valid_q, byte_errs_valid_d;
  logic             alarm_q, alarm_d;

  logic [7:0]       diff_s;
  logic [3:0]       pop_s;
  logic [ACC_W:0]   sum_s;
  logic             xfer_s;
  logic             over_thresh_s;

  assign diff_s = rx_byte_i ^ ref_byte_i;

  popcount8 u_popcount8 (
    .in_i  (diff_s),
    .cnt_o (pop_s)
  );

  assign xfer_s        = in_valid_i && (state_q == ST_RUN);
  // One extra carry bit detects overflow so the accumulator clamps instead of wrapping.
  assign sum_s         = {1'b0, err_total_q} + {{(ACC_W - 3){1'b0}}, pop_s};
  assign over_thresh_s = (33'(err_total_q) >= THRESH_X);

  // Next-state, counter, accumulator and output register updates.
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    err_total_d       = err_total_q;
    byte_errs_d       = byte_errs_q;
    byte_errs_valid_d = 1'b0;
    alarm_d           = alarm_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d     = ST_RUN;
          cnt_d       = '0;
          err_total_d = '0;
          byte_errs_d = 4'd0;
          alarm_d     = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (xfer_s) begin
          byte_errs_d       = pop_s;
          byte_errs_valid_d = 1'b1;
          err_total_d       = sum_s[ACC_W] ? ACC_MAX : sum_s[ACC_W-1:0];
          cnt_d             = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        // err_total already holds the final byte here, so the alarm decision is exact.
        alarm_d = over_thresh_s;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q           <= ST_IDLE;
      cnt_q             <= '0;
      err_total_q       <= '0;
      byte_errs_q       <= 4'd0;
      byte_errs_valid_q <= 1'b0;
      alarm_q           <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      err_total_q       <= err_total_d;
      byte_errs_q       <= byte_errs_d;
      byte_errs_valid_q <= byte_errs_valid_d;
      alarm_q           <= alarm_d;
    end
  end

  assign in_ready_o        = (state_q == ST_RUN);
  assign busy_o            = (state_q == ST_RUN);
  assign done_o            = (state_q == ST_DONE);
  assign byte_errs_o       = byte_errs_q;
  assign byte_errs_valid_o = byte_errs_valid_q;
  assign err_total_o       = err_total_q;
  assign alarm_o           = alarm_q;

endmodule

// File: tb/tb_bit_error_window.sv
// Self-checking bench for bit_error_window: a default 16/12/4 instance and a small
// 4/4/4 instance for saturation, checked against a popcount/min() reference model.
module tb_bit_error_window;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: W_BYTES=16, ACC_W=12, THRESH=4
  logic        rst_a, start_a, valid_a;
  logic [7:0]  rx_a, ref_a;
  logic        in_ready_a, bev_a, busy_a, done_a, alarm_a;
  logic [3:0]  berr_a;
  logic [11:0] total_a;

  // Instance B: W_BYTES=4, ACC_W=4, THRESH=4
  logic        rst_b, start_b, valid_b;
  logic [7:0]  rx_b, ref_b;
  logic        in_ready_b, bev_b, busy_b, done_b, alarm_b;
  logic [3:0]  berr_b;
  logic [3:0]  total_b;

  bit_error_window #(.W_BYTES(16), .ACC_W(12), .THRESH(4)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .start_i(start_a), .in_valid_i(valid_a),
    .rx_byte_i(rx_a), .ref_byte_i(ref_a), .in_ready_o(in_ready_a),
    .byte_errs_o(berr_a), .byte_errs_valid_o(bev_a), .err_total_o(total_a),
    .busy_o(busy_a), .done_o(done_a), .alarm_o(alarm_a)
  );

  bit_error_window #(.W_BYTES(4), .ACC_W(4), .THRESH(4)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .start_i(start_b), .in_valid_i(valid_b),
    .rx_byte_i(rx_b), .ref_byte_i(ref_b), .in_ready_o(in_ready_b),
    .byte_errs_o(berr_b), .byte_errs_valid_o(bev_b), .err_total_o(total_b),
    .busy_o(busy_b), .done_o(done_b), .alarm_o(alarm_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_total;

  function automatic int model_pop(input logic [7:0] a, input logic [7:0] b);
    return $countones(a ^ b);
  endfunction

  function automatic int model_acc(input int t, input int add, input int accw);
    int mx;
    mx = (1 << accw) - 1;
    return (t + add > mx) ? mx : t + add;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] rx, input logic [7:0] rf);
    valid_a = 1'b1; rx_a = rx; ref_a = rf;
    tick();
    valid_a = 1'b0; rx_a = 8'($urandom); ref_a = 8'($urandom);
  endtask

  task automatic send_b(input logic [7:0] rx, input logic [7:0] rf);
    valid_b = 1'b1; rx_b = rx; ref_b = rf;
    tick();
    valid_b = 1'b0;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; valid_a = 1'b1; rx_a = 8'hAA; ref_a = 8'h55;
    tick(); tick();
    rst_a = 1'b0; rst_b = 1'b0;
    n_checks++;
    if ({in_ready_a, bev_a, busy_a, done_a, alarm_a, berr_a, total_a} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_outputs_a: got rdy=%b bev=%b busy=%b done=%b alarm=%b berr=%0d total=%0d, want all 0",
               in_ready_a, bev_a, busy_a, done_a, alarm_a, berr_a, total_a);
    end
    n_checks++;
    if ({in_ready_b, bev_b, busy_b, done_b, alarm_b, berr_b, total_b} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs_b: got rdy=%b total=%0d, want all 0", in_ready_b, total_b);
    end
    tick();  // in_valid still high while IDLE
    valid_a = 1'b0;
    n_checks++;
    if (bev_a !== 1'b0 || total_a !== 12'd0 || in_ready_a !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ignores_valid: got bev=%b total=%0d rdy=%b, want 0 0 0", bev_a, total_a, in_ready_a);
    end
  endtask

  task automatic test_single_pair();
    start_a = 1'b1; tick(); start_a = 1'b0;
    n_checks++;
    if (busy_a !== 1'b1 || in_ready_a !== 1'b1) begin
      n_fail++;
      $display("FAIL start_to_run: got busy=%b rdy=%b, want 1 1", busy_a, in_ready_a);
    end
    send_a(8'hAA, 8'hFF);
    n_checks++;
    if (berr_a !== 4'd4 || bev_a !== 1'b1 || total_a !== 12'd4) begin
      n_fail++;
      $display("FAIL first_pair: got berr=%0d bev=%b total=%0d, want 4 1 4", berr_a, bev_a, total_a);
    end
    tick();
    n_checks++;
    if (bev_a !== 1'b0) begin
      n_fail++;
      $display("FAIL bev_pulse: got %b, want 0", bev_a);
    end
    for (int i = 1; i < 16; i++) begin
      send_a(8'h3C, 8'h3C);
      n_checks++;
      if (done_a !== (i == 15) || total_a !== 12'd4 || berr_a !== 4'd0) begin
        n_fail++;
        $display("FAIL single_window_%0d: got done=%b total=%0d berr=%0d, want done=%b 4 0",
                 i, done_a, total_a, berr_a, (i == 15));
      end
    end
    n_checks++;
    if (bev_a !== 1'b1 || busy_a !== 1'b0 || in_ready_a !== 1'b0) begin
      n_fail++;
      $display("FAIL done_cycle: got bev=%b busy=%b rdy=%b, want 1 0 0", bev_a, busy_a, in_ready_a);
    end
    tick();
    n_checks++;
    if (alarm_a !== 1'b1 || done_a !== 1'b0 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL alarm_at_thresh: got alarm=%b done=%b busy=%b, want 1 0 0", alarm_a, done_a, busy_a);
    end
  endtask

  task automatic test_gapped_window();
    int gap;
    int dones;
    dones = 0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    exp_total = 0;
    for (int i = 0; i < 16; i++) begin
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        start_a = 1'b1;  // start must be ignored while running
        tick();
        start_a = 1'b0;
        n_checks++;
        if (bev_a !== 1'b0 || done_a !== 1'b0 || total_a !== 12'(exp_total)) begin
          n_fail++;
          $display("FAIL gap_%0d: got bev=%b done=%b total=%0d, want 0 0 %0d", i, bev_a, done_a, total_a, exp_total);
        end
      end
      send_a(8'h00, 8'hFF);
      exp_total = model_acc(exp_total, model_pop(8'h00, 8'hFF), 12);
      if (done_a === 1'b1) dones++;
      n_checks++;
      if (berr_a !== 4'd8 || bev_a !== 1'b1 || total_a !== 12'(exp_total)) begin
        n_fail++;
        $display("FAIL gapped_pair_%0d: got berr=%0d bev=%b total=%0d, want 8 1 %0d", i, berr_a, bev_a, total_a, exp_total);
      end
    end
    tick();
    if (done_a === 1'b1) dones++;
    n_checks++;
    if (dones !== 1 || total_a !== 12'd128 || alarm_a !== 1'b1) begin
      n_fail++;
      $display("FAIL gapped_end: got dones=%0d total=%0d alarm=%b, want 1 128 1", dones, total_a, alarm_a);
    end
  endtask

  task automatic test_clean_window();
    logic [7:0] v;
    start_a = 1'b1; valid_a = 1'b1; rx_a = 8'h0F; ref_a = 8'hF0;
    tick();
    start_a = 1'b0; valid_a = 1'b0;
    n_checks++;
    if (alarm_a !== 1'b0 || total_a !== 12'd0 || bev_a !== 1'b0 || berr_a !== 4'd0 || busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL start_clears: got alarm=%b total=%0d bev=%b berr=%0d busy=%b, want 0 0 0 0 1",
               alarm_a, total_a, bev_a, berr_a, busy_a);
    end
    for (int i = 0; i < 16; i++) begin
      v = 8'($urandom);
      send_a(v, v);
      n_checks++;
      if (total_a !== 12'd0 || done_a !== (i == 15)) begin
        n_fail++;
        $display("FAIL clean_pair_%0d: got total=%0d done=%b, want 0 %b", i, total_a, done_a, (i == 15));
      end
    end
    tick();
    n_checks++;
    if (alarm_a !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_alarm: got %b, want 0", alarm_a);
    end
    start_a = 1'b1; tick(); start_a = 1'b0;
    n_checks++;
    if (total_a !== 12'd0 || busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL restart: got total=%0d busy=%b, want 0 1", total_a, busy_a);
    end
  endtask

  task automatic test_abort_reset();
    logic [7:0] r, f;
    int gap;
    // Instance A is already running a freshly started window.
    exp_total = 0;
    for (int i = 0; i < 5; i++) begin
      r = 8'($urandom); f = 8'($urandom);
      send_a(r, f);
      exp_total = model_acc(exp_total, model_pop(r, f), 12);
      n_checks++;
      if (total_a !== 12'(exp_total) || berr_a !== 4'(model_pop(r, f))) begin
        n_fail++;
        $display("FAIL pre_abort_%0d: got total=%0d berr=%0d, want %0d %0d", i, total_a, berr_a, exp_total, model_pop(r, f));
      end
    end
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    n_checks++;
    if (total_a !== 12'd0 || busy_a !== 1'b0 || done_a !== 1'b0 || in_ready_a !== 1'b0 || bev_a !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: got total=%0d busy=%b done=%b rdy=%b bev=%b, want all 0",
               total_a, busy_a, done_a, in_ready_a, bev_a);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (done_a !== 1'b0 || busy_a !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_done_%0d: got done=%b busy=%b, want 0 0", k, done_a, busy_a);
      end
    end
    start_a = 1'b1; tick(); start_a = 1'b0;
    exp_total = 0;
    for (int i = 0; i < 16; i++) begin
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) tick();
      r = 8'($urandom); f = 8'($urandom);
      send_a(r, f);
      exp_total = model_acc(exp_total, model_pop(r, f), 12);
      n_checks++;
      if (total_a !== 12'(exp_total) || berr_a !== 4'(model_pop(r, f)) || done_a !== (i == 15)) begin
        n_fail++;
        $display("FAIL rand_pair_%0d: got total=%0d berr=%0d done=%b, want %0d %0d %b",
                 i, total_a, berr_a, done_a, exp_total, model_pop(r, f), (i == 15));
      end
    end
    tick();
    n_checks++;
    if (alarm_a !== (exp_total >= 4)) begin
      n_fail++;
      $display("FAIL rand_alarm: got %b, want %b (total %0d)", alarm_a, (exp_total >= 4), exp_total);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] r, f;
    start_a = 1'b1; tick(); start_a = 1'b0;
    exp_total = 0;
    for (int i = 0; i < 16; i++) begin
      r = 8'($urandom); f = 8'($urandom);
      valid_a = 1'b1; rx_a = r; ref_a = f;
      tick();
      exp_total = model_acc(exp_total, model_pop(r, f), 12);
      n_checks++;
      if (total_a !== 12'(exp_total) || bev_a !== 1'b1 || done_a !== (i == 15)) begin
        n_fail++;
        $display("FAIL b2b_pair_%0d: got total=%0d bev=%b done=%b, want %0d 1 %b",
                 i, total_a, bev_a, done_a, exp_total, (i == 15));
      end
    end
    valid_a = 1'b0;
    start_a = 1'b1;  // held across DONE: ignored there, honoured in IDLE
    tick();
    n_checks++;
    if (busy_a !== 1'b0 || alarm_a !== (exp_total >= 4) || total_a !== 12'(exp_total)) begin
      n_fail++;
      $display("FAIL start_in_done: got busy=%b alarm=%b total=%0d, want 0 %b %0d",
               busy_a, alarm_a, total_a, (exp_total >= 4), exp_total);
    end
    tick();
    start_a = 1'b0;
    n_checks++;
    if (busy_a !== 1'b1 || total_a !== 12'd0 || alarm_a !== 1'b0) begin
      n_fail++;
      $display("FAIL start_after_done: got busy=%b total=%0d alarm=%b, want 1 0 0", busy_a, total_a, alarm_a);
    end
  endtask

  task automatic test_saturate();
    logic [7:0] r, f;
    start_b = 1'b1; tick(); start_b = 1'b0;
    exp_total = 0;
    for (int i = 0; i < 3; i++) begin
      send_b(8'h00, 8'hFF);
      exp_total = model_acc(exp_total, 8, 4);
      n_checks++;
      if (total_b !== 4'(exp_total) || berr_b !== 4'd8) begin
        n_fail++;
        $display("FAIL sat_pair_%0d: got total=%0d berr=%0d, want %0d 8", i, total_b, berr_b, exp_total);
      end
    end
    r = 8'($urandom); f = 8'($urandom);
    send_b(r, f);
    exp_total = model_acc(exp_total, model_pop(r, f), 4);
    n_checks++;
    if (total_b !== 4'(exp_total) || done_b !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_last: got total=%0d done=%b, want %0d 1", total_b, done_b, exp_total);
    end
    tick();
    n_checks++;
    if (alarm_b !== 1'b1 || done_b !== 1'b0 || total_b !== 4'd15) begin
      n_fail++;
      $display("FAIL sat_alarm: got alarm=%b done=%b total=%0d, want 1 0 15", alarm_b, done_b, total_b);
    end
  endtask

  initial begin
    rst_a = 1'b1; start_a = 1'b0; valid_a = 1'b0; rx_a = 8'h00; ref_a = 8'h00;
    rst_b = 1'b1; start_b = 1'b0; valid_b = 1'b0; rx_b = 8'h00; ref_b = 8'h00;
    test_reset();
    test_single_pair();
    test_gapped_window();
    test_clean_window();
    test_abort_reset();
    test_back_to_back();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
